sp_ram_bist_ctrl: RTL and testbench

//  Upstream driver for the 32-bit single-port RAM (sp_ram). The controller runs a self-test in
//  two passes: it writes an LFSR pattern to every word, then reads every word back and compares
//  ram_q with the regenerated pattern. It reports pass/fail, an error count and the first failing

---
 rtl/sp_ram_bist_pkg.sv | 20 ++
 rtl/sp_ram_bist_ctrl_lfsr.sv | 29 ++
 rtl/sp_ram_bist_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sp_ram_bist_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_bist_pkg.sv
// Shared types, constants and LFSR step function for the sp_ram BIST controller.
package sp_ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam int          ERR_W     = 16;

   // Galois form, right shift: the feedback taps are XORed in when bit 0 falls out.
   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/sp_ram_bist_ctrl_lfsr.sv
// 32-bit Galois LFSR with load and advance enables; reset and load both restore SEED.
module bist_lfsr32
   import sp_ram_bist_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_adv,
   output logic [31:0] o_value
);

   logic [31:0] r_lfsr;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (i_load) begin
         r_lfsr <= SEED;
      end else if (i_adv) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_value = r_lfsr;

endmodule

// File: rtl/sp_ram_bist_ctrl.sv
// Two-pass RAM self-test: write an LFSR pattern to every word, read back, count mismatches.
module sp_ram_bist_ctrl
   import sp_ram_bist_pkg::*;
#(
   parameter int          DW      = 32,
   parameter int          AW      = 10,
   parameter int          N_WORDS = 32,
   parameter int          RD_LAT  = 1,
   parameter logic [31:0] SEED    = 32'h1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [AW-1:0]    ram_addr,
   output logic [DW-1:0]    ram_data,
   output logic             ram_we,
   input  logic [DW-1:0]    ram_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [AW-1:0]    first_err_addr
);

   localparam logic [31:0]      SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [AW-1:0]    LAST_ADDR  = AW'(N_WORDS - 1);
   localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);
   localparam int               REP        = (DW + 31) / 32;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   if (N_WORDS < 1 || N_WORDS > (1 << AW)) begin : g_bad_n_words
      $error("sp_ram_bist_ctrl: N_WORDS must be in 1..2**AW");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("sp_ram_bist_ctrl: RD_LAT must be in 1..4");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_start_ok;
   logic              w_load;
   logic              w_adv;
   logic              w_push;
   logic              w_last;
   logic              w_mis;
   logic [31:0]       w_lfsr;

   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_data;
   logic              r_we;
   logic [1:0]        r_drain;
   logic [ERR_W-1:0]  r_err;
   logic [AW-1:0]     r_first;

   logic [RD_LAT-1:0] r_pv;
   logic [DW-1:0]     r_pe [RD_LAT];
   logic [AW-1:0]     r_pa [RD_LAT];

   function automatic logic [DW-1:0] pat(input logic [31:0] x);
      logic [REP*32-1:0] rep;
      rep = {REP{x}};
      return rep[DW-1:0];
   endfunction

   bist_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_adv   (w_adv),
      .o_value (w_lfsr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_push      = 1'b0;
      w_last      = (r_addr == LAST_ADDR);
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = WRITE;
               w_start_ok  = 1'b1;
               w_load      = 1'b1;
            end
         end
         WRITE: begin
            if (w_last) begin
               w_state_nxt = READ;
               w_load      = 1'b1;
            end else begin
               w_adv = 1'b1;
            end
         end
         READ: begin
            w_push = 1'b1;
            if (w_last) w_state_nxt = DRAIN;
            else        w_adv       = 1'b1;
         end
         DRAIN: begin
            if (r_drain == DRAIN_LAST) w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (abort) begin
         w_state_nxt = IDLE;
         w_start_ok  = 1'b0;
         w_load      = 1'b0;
         w_adv       = 1'b0;
         w_push      = 1'b0;
      end
   end

   // Compare the oldest outstanding read; abort freezes the result counters.
   assign w_mis = r_pv[RD_LAT-1] && (ram_q !== r_pe[RD_LAT-1]) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_drain <= '0;
         r_err   <= '0;
         r_first <= '0;
         r_pv    <= '0;
      end else begin
         r_we    <= (w_state_nxt == WRITE);
         r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;

         if (w_load)     r_addr <= '0;
         else if (w_adv) r_addr <= r_addr + 1'b1;

         if (w_start_ok)                      r_data <= pat(SEED_EFF);
         else if (w_adv && r_state == WRITE)  r_data <= pat(lfsr_next(w_lfsr));

         if (w_start_ok) begin
            r_err   <= '0;
            r_first <= '0;
         end else if (w_mis) begin
            if (r_err == '0)     r_first <= r_pa[RD_LAT-1];
            if (r_err != ERR_MAX) r_err  <= r_err + 1'b1;
         end

         if (abort || w_start_ok) r_pv <= '0;
         else                     r_pv <= RD_LAT'({r_pv, w_push});
      end
   end

   // NOTE: only the valid bits need reset; the expected-data/address payload is don't-care while invalid.
   always_ff @(posedge clk) begin
      r_pe[0] <= pat(w_lfsr);
      r_pa[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         r_pe[i] <= r_pe[i-1];
         r_pa[i] <= r_pa[i-1];
      end
   end

   assign ram_addr       = r_addr;
   assign ram_data       = r_data;
   assign ram_we         = r_we;
   assign busy           = (r_state == WRITE) || (r_state == READ) || (r_state == DRAIN);
   assign done           = (r_state == DONE);
   assign pass           = done && (r_err == '0);
   assign err_count      = r_err;
   assign first_err_addr = r_first;

endmodule

// File: tb/tb_sp_ram_bist_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT 1 and 3) on behavioural RAMs with injected read faults.
module tb_sp_ram_bist_ctrl;

   localparam int          DW   = 32;
   localparam int          AW   = 10;
   localparam int          N    = 32;
   localparam logic [31:0] SEED = 32'h1;
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef struct {
      int err;
      int first;
      bit pass;
      int cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;

   logic [AW-1:0] addr1, addr3, f1, f3;
   logic [DW-1:0] data1, data3, q1, q3;
   logic          we1, we3, b1, b3, d1, d3, p1, p3;
   logic [15:0]   e1, e3;

   logic [31:0]   mem1 [1024];
   logic [31:0]   mem3 [1024];
   logic [31:0]   flip [1024];
   logic [31:0]   stuck;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra3 [3];
   logic [31:0]   pats [N];

   exp_t q_exp1[$];
   exp_t q_exp3[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt [2];
   bit   pbusy [2];
   bit   pdone [2];

   always #5 clk = ~clk;

   sp_ram_bist_ctrl #(.DW(DW), .AW(AW), .N_WORDS(N), .RD_LAT(1), .SEED(SEED)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .ram_addr(addr1), .ram_data(data1), .ram_we(we1), .ram_q(q1),
      .busy(b1), .done(d1), .pass(p1), .err_count(e1), .first_err_addr(f1)
   );

   sp_ram_bist_ctrl #(.DW(DW), .AW(AW), .N_WORDS(N), .RD_LAT(3), .SEED(SEED)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .ram_addr(addr3), .ram_data(data3), .ram_we(we3), .ram_q(q3),
      .busy(b3), .done(d3), .pass(p3), .err_count(e3), .first_err_addr(f3)
   );

   // Behavioural single-port RAMs; read faults are applied on the q path only.
   always @(posedge clk) begin
      if (we1) mem1[addr1] <= data1;
      if (we3) mem3[addr3] <= data3;
      ra1    <= addr1;
      ra3[0] <= addr3;
      ra3[1] <= ra3[0];
      ra3[2] <= ra3[1];
   end
   assign q1 = (mem1[ra1] ^ flip[ra1]) | stuck;
   assign q3 = (mem3[ra3[2]] ^ flip[ra3[2]]) | stuck;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk every address, apply the fault to the written pattern, count differences.
   function automatic exp_t build_exp(input int lat);
      exp_t        e;
      logic [31:0] r;
      e.err   = 0;
      e.first = 0;
      e.cyc   = 2 * N + lat;
      for (int a = 0; a < N; a++) begin
         r = (pats[a] ^ flip[a]) | stuck;
         if (r != pats[a]) begin
            if (e.err == 0) e.first = a;
            e.err++;
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   task automatic mon(input int id, input logic b, input logic d, input logic [15:0] ec,
                      input logic [AW-1:0] fa, input logic p);
      exp_t  e;
      string tag;
      tag = (id == 0) ? "lat1" : "lat3";
      if (b && !pbusy[id]) cnt[id] = 1;
      else if (b)          cnt[id]++;
      if (d && !pdone[id]) begin
         if ((id == 0 && q_exp1.size() == 0) || (id == 1 && q_exp3.size() == 0)) begin
            check({tag, " unexpected done"}, 64'd1, 64'd0);
         end else begin
            if (id == 0) e = q_exp1.pop_front();
            else         e = q_exp3.pop_front();
            check({tag, " err_count"}, 64'(ec), 64'(e.err));
            check({tag, " first_err_addr"}, 64'(fa), 64'(e.first));
            check({tag, " pass"}, 64'(p), 64'(e.pass));
            check({tag, " busy cycles"}, 64'(cnt[id]), 64'(e.cyc));
         end
      end
      pbusy[id] = b;
      pdone[id] = d;
   endtask

   always @(negedge clk) begin
      mon(0, b1, d1, e1, f1, p1);
      mon(1, b3, d3, e3, f3, p3);
   end

   task automatic clear_faults();
      for (int a = 0; a < 1024; a++) flip[a] = 32'h0;
      stuck = 32'h0;
   endtask

   task automatic random_faults();
      int mode;
      mode = int'($urandom_range(0, 3));
      case (mode)
         1: flip[$urandom_range(0, N-1)] = 32'h1 << $urandom_range(0, 31);
         2: stuck = 32'h1 << $urandom_range(0, 31);
         3: for (int a = 0; a < N; a++) if ($urandom_range(0, 7) == 0) flip[a] = $urandom | 32'h1;
         default: ;
      endcase
   endtask

   task automatic check_zero(input string tag);
      check({tag, " lat1 data"}, 64'(data1), 64'd0);
      check({tag, " lat1 ctrl/status"}, 64'({addr1, we1, b1, d1, p1, e1, f1}), 64'd0);
      check({tag, " lat3 data"}, 64'(data3), 64'd0);
      check({tag, " lat3 ctrl/status"}, 64'({addr3, we3, b3, d3, p3, e3, f3}), 64'd0);
   endtask

   task automatic start_run(input bit push);
      if (push) begin
         q_exp1.push_back(build_exp(1));
         q_exp3.push_back(build_exp(3));
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("lat1 first write cycle", 64'({we1, b1, d1, addr1}), 64'({1'b1, 1'b1, 1'b0, 10'd0}));
      check("lat3 first write cycle", 64'({we3, b3, d3, addr3}), 64'({1'b1, 1'b1, 1'b0, 10'd0}));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(d1 && d3) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("run reaches done", 64'({d1, d3}), 64'(2'b11));
   endtask

   task automatic check_mem();
      int bad1, bad3;
      bad1 = 0;
      bad3 = 0;
      for (int a = 0; a < N; a++) begin
         if (mem1[a] !== pats[a]) bad1++;
         if (mem3[a] !== pats[a]) bad3++;
      end
      check("lat1 ram words wrong", 64'(bad1), 64'd0);
      check("lat3 ram words wrong", 64'(bad3), 64'd0);
   endtask

   initial begin
      int n;
      clear_faults();
      pats[0] = SEED;
      for (int a = 1; a < N; a++) pats[a] = (pats[a-1] >> 1) ^ (pats[a-1][0] ? POLY : 32'h0);

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Clean run: known first two pattern words.
      start_run(1'b1);
      wait_done();
      check_mem();
      check("addr0 pattern", 64'(mem1[0]), 64'h0000_0001);
      check("addr1 pattern", 64'(mem1[1]), 64'h8020_0003);

      // Single bit-0 flip on the read of address 5.
      flip[5] = 32'h1;
      start_run(1'b1);
      wait_done();
      clear_faults();

      // Bit 31 stuck high on every read.
      stuck = 32'h8000_0000;
      start_run(1'b1);
      wait_done();
      clear_faults();

      // Abort during WRITE at address 10.
      start_run(1'b0);
      n = 0;
      while (!(we1 && addr1 == 10) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort point reached", 64'(addr1), 64'd10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("lat1 after abort", 64'({we1, b1, d1, p1}), 64'd0);
      check("lat3 after abort", 64'({we3, b3, d3, p3}), 64'd0);

      // Abort together with start: abort wins.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort beats start", 64'({b1, b3, we1, we3}), 64'd0);

      random_faults();
      start_run(1'b1);
      wait_done();
      check_mem();
      clear_faults();

      // Asynchronous reset in the middle of READ.
      start_run(1'b0);
      repeat (N + 5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("mid-read reset");
      @(negedge clk);
      rst_n = 1'b1;
      start_run(1'b1);
      wait_done();
      check_mem();

      // start during READ is ignored; start from DONE re-runs.
      start_run(1'b1);
      repeat (N + 3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      start_run(1'b1);
      wait_done();

      for (int r = 0; r < 6; r++) begin
         random_faults();
         start_run(1'b1);
         wait_done();
         check_mem();
         clear_faults();
      end

      repeat (2) @(negedge clk);
      check("pending expectations", 64'(q_exp1.size() + q_exp3.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
